// File: rtl/dot_sched_pkg.sv
// dot_sched_pkg: shared FSM state type and width/lane helpers for the dot product scheduler
package dot_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int pw_f(input int n, input int dw);
    return 2 * dw + $clog2(n + 1);
  endfunction
  function automatic int lane_lo(input int i, input int dw);
    return i * dw;
  endfunction
endpackage

// File: rtl/chunk_dot.sv
// chunk_dot: combinational N-lane unsigned multiply and reduce into a PW-bit chunk sum
module chunk_dot
  import dot_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int PW = pw_f(4, 8)
) (
  input  logic [DW*N-1:0] a,
  input  logic [DW*N-1:0] b,
  output logic [PW-1:0]   sum
);
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++)
      sum = sum + PW'(a[lane_lo(i, DW) +: DW]) * PW'(b[lane_lo(i, DW) +: DW]);
  end
endmodule

// File: rtl/dot_product_sched.sv
// dot_product_sched: chunked dot product job sequencer (DOT_SAT_EN selects saturating accumulate)
module dot_product_sched
  import dot_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32,
  parameter int LW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [LW-1:0]   start_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW*N-1:0] in_a,
  input  logic [DW*N-1:0] in_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [AW-1:0]   res_data,
  output logic            res_ovf,
  output logic            busy
);
  localparam int PW = pw_f(N, DW);
  if (AW < PW) begin : g_aw_chk
    $error("dot_product_sched: AW must be at least PW");
  end
  state_t        state;
  logic [LW-1:0] len, cnt;
  logic [AW-1:0] acc;
  logic [PW-1:0] p_reg, p_sum;
  logic          p_vld;
  chunk_dot #(.N(N), .DW(DW), .PW(PW)) u_dot (.a(in_a), .b(in_b), .sum(p_sum));
  always_comb begin
    start_ready = state == IDLE;
    in_ready    = state == RUN;
    res_valid   = state == DONE;
    res_data    = state == DONE ? acc : '0;
    busy        = state != IDLE;
  end
`ifdef DOT_SAT_EN
  logic [AW:0] acc_sum;
  logic        ovf;
  assign acc_sum = {1'b0, acc} + (AW+1)'(p_reg);
  assign res_ovf = state == DONE && ovf;
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (state == IDLE && start_valid) ovf <= 1'b0;
    else if (p_vld && acc_sum[AW]) ovf <= 1'b1;
`else
  assign res_ovf = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
      acc   <= '0;
      p_reg <= '0;
      p_vld <= 1'b0;
    end else begin
`ifdef DOT_SAT_EN
      if (p_vld) acc <= acc_sum[AW] ? '1 : acc_sum[AW-1:0];
`else
      if (p_vld) acc <= acc + AW'(p_reg);
`endif
      case (state)
        IDLE: if (start_valid) begin
          len   <= start_len;
          cnt   <= '0;
          acc   <= '0;
          state <= start_len == '0 ? DONE : RUN;
        end
        RUN: begin
          p_vld <= in_valid;
          if (in_valid) begin
            cnt   <= cnt + 1'b1;
            p_reg <= p_sum;
            if (cnt == len - 1'b1) state <= DRAIN;
          end
        end
        DRAIN: begin
          p_vld <= 1'b0;
          state <= DONE;
        end
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
